mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage controller sitting downstream of the EX/MEM pipeline register, on the consuming side of its outputs. Turns the registered load/store controls into a req/ack transaction on a variable-latency data-memory port. Stalls the upstream pipeline while a transaction is outstanding. Selects the write-back result and registers it into the MEM/WB stage.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `DATA_W`, default 32: data word width; word accesses only.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `RegWrite_MEM` in 1: instruction writes the register file.
- `MemToReg_MEM` in 1: load.
- `MemWrite_MEM` in 1: store.
- `JAL_MEM` in 1: result is PCPlus4.
- `AluOut_MEM` in 32: effective address, or ALU result.
- `RtD_MEM` in 32: store data.
- `PCPlus4_MEM` in 32: link value.
- `WriteReg_MEM` in 5: destination register.
- `Stall_MEM` out 1: freezes PC, IF/ID, ID/EX and EX/MEM (their enables are `!Stall_MEM`).
- `dmem_req` out 1: transaction request, registered.
- `dmem_we` out 1: 1 = write, registered.
- `dmem_addr` out ADDR_W: word-aligned address, registered.
- `dmem_wdata` out DATA_W: store data, registered.
- `dmem_ack` in 1: transaction complete; read data valid this cycle.
- `dmem_rdata` in DATA_W: load data.
- `RegWrite_WB` out 1: registered write-back enable.
- `WriteReg_WB` out 5: registered destination.
- `Result_WB` out 32: registered write-back value.

## Operation
- A memory op is `MemToReg_MEM | MemWrite_MEM`.
- FSM states:
  - **IDLE:** if a memory op is present, latch address/we/wdata, set `dmem_req`, go to ACCESS. Otherwise stay.
  - **ACCESS:** hold `dmem_req` and all `dmem_*` outputs stable. On `dmem_ack`: capture `dmem_rdata`, drop `dmem_req`, go to DONE.
  - **DONE:** one cycle, then IDLE.
- `Stall_MEM` is combinational: `(IDLE & memop) | ACCESS`. It is low in DONE, so EX/MEM advances at the end of DONE.
- `dmem_addr = {AluOut_MEM[ADDR_W-1:2], 2'b00}`. Low address bits are ignored.
- `dmem_we = MemWrite_MEM` at latch time.
- Result select priority:
  - `JAL_MEM` → `PCPlus4_MEM`
  - else `MemToReg_MEM` → captured read data
  - else `AluOut_MEM`
- MEM/WB load rule:
  - Non-memory instruction in IDLE: WB regs load `RegWrite_MEM`, `WriteReg_MEM` and the selected result.
  - Memory op: WB regs load only in DONE.
  - In all stall cycles, WB regs load a bubble (`RegWrite_WB` = 0, others 0). Each instruction therefore writes back exactly once.
- `dmem_ack` outside ACCESS is ignored.
- Store: `RegWrite_WB` follows `RegWrite_MEM` (0 for correct decode). Result is don't-care but must be deterministic: the read-data path is 0 for stores.
- `JAL_MEM` together with a memory op is illegal decode. JAL wins the result mux; the memory access still occurs.

## Timing
- Reset (async assert, sync to clk on release):
  - state IDLE
  - `dmem_req` = 0, `dmem_we` = 0, `dmem_addr` = 0, `dmem_wdata` = 0
  - `RegWrite_WB` = 0, `WriteReg_WB` = 0, `Result_WB` = 0
  - `Stall_MEM` follows its equation; it is 0 with EX/MEM in reset.
- Non-memory instruction: zero added latency. `Result_WB` is valid the cycle after it is presented.
- Memory op with ack after N ACCESS cycles (N ≥ 1): stall for N+1 cycles, then DONE.
- `dmem_req` rises 1 cycle after detect. WB is valid the cycle after DONE.
- Minimum (ack in first ACCESS cycle): detect, ACCESS, DONE = 3 cycles in MEM.
- Back-to-back memory ops: DONE → IDLE → the next op is detected in the following cycle. There is no overlap, and `dmem_req` has at least 1 low cycle between transactions.
- Reset mid-ACCESS:
  - abort immediately, `dmem_req` low
  - a late ack after reset release is ignored
  - no WB write occurs for the aborted instruction.

## Structure
- Shared package `mem_pkg`:
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2
  - result-select constants: SEL_ALU, SEL_MEM, SEL_LINK
- Sub-module `mem_wb_reg`: the MEM/WB pipeline register with a bubble input and async reset.
- Top-level contents: FSM, request latch, result mux.

## Test plan
- **ALU op:** `AluOut_MEM`=0x1234, `RegWrite_MEM`=1, `WriteReg_MEM`=5 → next cycle `Result_WB`=0x1234, `RegWrite_WB`=1; `Stall_MEM` never high.
- **Load:** addr 0x103, ack after 3 cycles with rdata 0xDEADBEEF →
  - `dmem_addr`=0x100, `dmem_we`=0
  - `Stall_MEM` high 4 cycles
  - exactly one WB cycle with `Result_WB`=0xDEADBEEF
  - bubbles before it.
- **Store:** addr 0x40, `RtD_MEM`=0xA5A5A5A5, ack in first ACCESS cycle → `dmem_we`=1, wdata stable until ack, stall 2 cycles, `RegWrite_WB`=0.
- **JAL:** `PCPlus4_MEM`=0x0000_0408, WriteReg=31 → `Result_WB`=0x408, no `dmem_req`.
- **Back-to-back loads, stray ack:**
  - `dmem_req` low ≥1 cycle between the two transactions
  - an ack pulse in IDLE changes nothing.
- **Reset mid-ACCESS:** assert reset with `dmem_req`=1 → all outputs 0 within the same cycle (async); ack after release is ignored and there is no WB write.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared MEM-stage types: FSM state encoding and write-back result select.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memState_t;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_LINK = 2'd2
  } resultSel_t;

  // JAL outranks load so an illegal JAL+memop decode still writes the link value.
  function automatic resultSel_t selResult(input logic jal, input logic memToReg);
    if (jal)           return SEL_LINK;
    else if (memToReg) return SEL_MEM;
    else               return SEL_ALU;
  endfunction

endpackage

// File: rtl/mem_access_unit_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble loads an all-zero (no write-back) slot.
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        regWrite,
  input  logic [4:0]  writeReg,
  input  logic [31:0] result,
  output logic        RegWrite_WB,
  output logic [4:0]  WriteReg_WB,
  output logic [31:0] Result_WB
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite_WB <= 1'b0;
      WriteReg_WB <= '0;
      Result_WB   <= '0;
    end else if (bubble) begin
      RegWrite_WB <= 1'b0;
      WriteReg_WB <= '0;
      Result_WB   <= '0;
    end else begin
      RegWrite_WB <= regWrite;
      WriteReg_WB <= writeReg;
      Result_WB   <= result;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: req/ack data-memory transaction, pipeline stall,
// write-back result select and MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_MEM,
  input  logic              MemToReg_MEM,
  input  logic              MemWrite_MEM,
  input  logic              JAL_MEM,
  input  logic [31:0]       AluOut_MEM,
  input  logic [31:0]       RtD_MEM,
  input  logic [31:0]       PCPlus4_MEM,
  input  logic [4:0]        WriteReg_MEM,
  output logic              Stall_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              RegWrite_WB,
  output logic [4:0]        WriteReg_WB,
  output logic [31:0]       Result_WB
);

  memState_t   state;
  logic [31:0] rdCap;
  logic [31:0] resultSel;
  logic        memOp;

  assign memOp     = MemToReg_MEM | MemWrite_MEM;
  assign Stall_MEM = ((state == IDLE) && memOp) || (state == ACCESS);

  // Request outputs are latched on detect and held untouched through ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      rdCap      <= '0;
    end else begin
      case (state)
        IDLE: if (memOp) begin
          dmem_req   <= 1'b1;
          dmem_we    <= MemWrite_MEM;
          dmem_addr  <= ADDR_W'({AluOut_MEM[31:2], 2'b00});
          dmem_wdata <= DATA_W'(RtD_MEM);
          state      <= ACCESS;
        end
        ACCESS: if (dmem_ack) begin
          dmem_req <= 1'b0;
          // Stores capture zero so their (unused) result stays deterministic.
          rdCap    <= dmem_we ? 32'd0 : 32'(dmem_rdata);
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    resultSel = AluOut_MEM;
    case (selResult(JAL_MEM, MemToReg_MEM))
      SEL_LINK: resultSel = PCPlus4_MEM;
      SEL_MEM:  resultSel = rdCap;
      default:  resultSel = AluOut_MEM;
    endcase
  end

  // Stall cycles are exactly the cycles that must not write back.
  mem_wb_reg uWb (
    .clk         (clk),
    .reset       (reset),
    .bubble      (Stall_MEM),
    .regWrite    (RegWrite_MEM),
    .writeReg    (WriteReg_MEM),
    .result      (resultSel),
    .RegWrite_WB (RegWrite_WB),
    .WriteReg_WB (WriteReg_WB),
    .Result_WB   (Result_WB)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the bench plays the EX/MEM register
// (holds the instruction while Stall_MEM) and the data memory (acks on demand).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_MEM, MemToReg_MEM, MemWrite_MEM, JAL_MEM;
  logic [31:0] AluOut_MEM, RtD_MEM, PCPlus4_MEM;
  logic [4:0]  WriteReg_MEM;
  logic        Stall_MEM, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        RegWrite_WB;
  logic [4:0]  WriteReg_WB;
  logic [31:0] Result_WB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_MEM(RegWrite_MEM), .MemToReg_MEM(MemToReg_MEM),
    .MemWrite_MEM(MemWrite_MEM), .JAL_MEM(JAL_MEM),
    .AluOut_MEM(AluOut_MEM), .RtD_MEM(RtD_MEM), .PCPlus4_MEM(PCPlus4_MEM),
    .WriteReg_MEM(WriteReg_MEM), .Stall_MEM(Stall_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .Result_WB(Result_WB)
  );

  task automatic clearIn();
    RegWrite_MEM = 0; MemToReg_MEM = 0; MemWrite_MEM = 0; JAL_MEM = 0;
    AluOut_MEM = 0; RtD_MEM = 0; PCPlus4_MEM = 0; WriteReg_MEM = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Entered just after a negedge. Presents one instruction, holds it while
  // stalled, acks in the ackAt-th ACCESS cycle, and returns just after the
  // negedge following the consuming posedge (WB outputs then show it).
  task automatic runInstr(
    input  logic rw, mtr, mw, jal,
    input  logic [31:0] alu, rtd, pc4,
    input  logic [4:0] wr,
    input  int ackAt,
    input  logic [31:0] rdata,
    output int stallCnt, output int reqCnt,
    output logic [31:0] addrSeen, output logic weSeen, output logic [31:0] wdataSeen,
    output logic unstable, output logic wbInStall, output logic reqAtDetect,
    output logic timeout);
    RegWrite_MEM = rw; MemToReg_MEM = mtr; MemWrite_MEM = mw; JAL_MEM = jal;
    AluOut_MEM = alu; RtD_MEM = rtd; PCPlus4_MEM = pc4; WriteReg_MEM = wr;
    dmem_rdata = rdata;
    stallCnt = 0; reqCnt = 0; unstable = 0; wbInStall = 0; timeout = 1;
    addrSeen = 0; weSeen = 0; wdataSeen = 0; reqAtDetect = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (c == 0) reqAtDetect = dmem_req;
      if (dmem_req) begin
        reqCnt++;
        if (reqCnt == 1) begin
          addrSeen = dmem_addr; weSeen = dmem_we; wdataSeen = dmem_wdata;
        end else if (dmem_addr !== addrSeen || dmem_we !== weSeen || dmem_wdata !== wdataSeen)
          unstable = 1;
      end
      dmem_ack = (dmem_req && reqCnt == ackAt);
      if (c > 0 && (RegWrite_WB || WriteReg_WB != 0 || Result_WB != 0)) wbInStall = 1;
      if (!Stall_MEM) begin timeout = 0; break; end
      stallCnt++;
      @(negedge clk);
    end
    @(negedge clk);
    clearIn();
  endtask

  int          sc, rc;
  logic [31:0] aS, wdS;
  logic        weS, uns, wbs, rq0, tmo;

  task automatic test_reset();
    reset = 1; clearIn();
    #3;
    checks++; if (dmem_req !== 0 || dmem_we !== 0) begin errors++;
      $display("FAIL reset_req_we: req=%b we=%b expected 0 0", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 0 || dmem_wdata !== 0) begin errors++;
      $display("FAIL reset_addr_wdata: addr=%h wdata=%h expected 0 0", dmem_addr, dmem_wdata); end
    checks++; if (RegWrite_WB !== 0 || WriteReg_WB !== 0 || Result_WB !== 0) begin errors++;
      $display("FAIL reset_wb: rw=%b wr=%0d res=%h expected 0", RegWrite_WB, WriteReg_WB, Result_WB); end
    checks++; if (Stall_MEM !== 0) begin errors++;
      $display("FAIL reset_stall: got %b expected 0", Stall_MEM); end
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    runInstr(1, 0, 0, 0, 32'h1234, 0, 0, 5'd5, 0, 0, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (sc !== 0 || rc !== 0) begin errors++;
      $display("FAIL alu_nostall: stall=%0d req=%0d expected 0 0", sc, rc); end
    checks++; if (Result_WB !== 32'h1234 || RegWrite_WB !== 1 || WriteReg_WB !== 5) begin errors++;
      $display("FAIL alu_wb: res=%h rw=%b wr=%0d expected 1234 1 5", Result_WB, RegWrite_WB, WriteReg_WB); end
    @(negedge clk);
    checks++; if (RegWrite_WB !== 0) begin errors++;
      $display("FAIL alu_after: rw=%b expected 0", RegWrite_WB); end
  endtask

  task automatic test_load();
    runInstr(1, 1, 0, 0, 32'h103, 0, 0, 5'd7, 3, 32'hDEADBEEF, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (tmo !== 0) begin errors++; $display("FAIL load_timeout: no completion"); end
    checks++; if (aS !== 32'h100 || weS !== 0) begin errors++;
      $display("FAIL load_req: addr=%h we=%b expected 100 0", aS, weS); end
    checks++; if (sc !== 4 || rc !== 3) begin errors++;
      $display("FAIL load_stall: stall=%0d req=%0d expected 4 3", sc, rc); end
    checks++; if (wbs !== 0) begin errors++; $display("FAIL load_bubble: write-back seen during stall"); end
    checks++; if (Result_WB !== 32'hDEADBEEF || RegWrite_WB !== 1 || WriteReg_WB !== 7) begin errors++;
      $display("FAIL load_wb: res=%h rw=%b wr=%0d expected deadbeef 1 7", Result_WB, RegWrite_WB, WriteReg_WB); end
    @(negedge clk);
    checks++; if (RegWrite_WB !== 0 || dmem_req !== 0) begin errors++;
      $display("FAIL load_once: rw=%b req=%b expected 0 0", RegWrite_WB, dmem_req); end
  endtask

  task automatic test_store();
    runInstr(0, 0, 1, 0, 32'h40, 32'hA5A5A5A5, 0, 5'd0, 1, 32'h77777777, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (aS !== 32'h40 || weS !== 1 || wdS !== 32'hA5A5A5A5 || uns !== 0) begin errors++;
      $display("FAIL store_req: addr=%h we=%b wdata=%h unstable=%b expected 40 1 a5a5a5a5 0", aS, weS, wdS, uns); end
    checks++; if (sc !== 2 || tmo !== 0) begin errors++;
      $display("FAIL store_stall: stall=%0d timeout=%b expected 2 0", sc, tmo); end
    checks++; if (RegWrite_WB !== 0) begin errors++;
      $display("FAIL store_wb: rw=%b expected 0", RegWrite_WB); end
  endtask

  task automatic test_jal();
    runInstr(1, 0, 0, 1, 32'h999, 0, 32'h0000_0408, 5'd31, 0, 0, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (rc !== 0 || sc !== 0) begin errors++;
      $display("FAIL jal_noreq: req=%0d stall=%0d expected 0 0", rc, sc); end
    checks++; if (Result_WB !== 32'h408 || WriteReg_WB !== 31 || RegWrite_WB !== 1) begin errors++;
      $display("FAIL jal_wb: res=%h wr=%0d rw=%b expected 408 31 1", Result_WB, WriteReg_WB, RegWrite_WB); end
  endtask

  task automatic test_back_to_back();
    runInstr(1, 1, 0, 0, 32'h200, 0, 0, 5'd3, 2, 32'h11111111, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (Result_WB !== 32'h11111111 || sc !== 3) begin errors++;
      $display("FAIL b2b_first: res=%h stall=%0d expected 11111111 3", Result_WB, sc); end
    runInstr(1, 1, 0, 0, 32'h20B, 0, 0, 5'd4, 1, 32'h22222222, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (rq0 !== 0 || sc !== 2 || aS !== 32'h208) begin errors++;
      $display("FAIL b2b_second: reqAtDetect=%b stall=%0d addr=%h expected 0 2 208", rq0, sc, aS); end
    checks++; if (Result_WB !== 32'h22222222 || WriteReg_WB !== 4) begin errors++;
      $display("FAIL b2b_wb: res=%h wr=%0d expected 22222222 4", Result_WB, WriteReg_WB); end
    // Stray ack while idle must not start or complete anything.
    dmem_ack = 1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk); dmem_ack = 0;
    #1;
    checks++; if (dmem_req !== 0 || Stall_MEM !== 0 || RegWrite_WB !== 0) begin errors++;
      $display("FAIL stray_ack: req=%b stall=%b rw=%b expected 0 0 0", dmem_req, Stall_MEM, RegWrite_WB); end
    @(negedge clk);
    runInstr(1, 0, 0, 0, 32'h55, 0, 0, 5'd9, 0, 0, sc, rc, aS, weS, wdS, uns, wbs, rq0, tmo);
    checks++; if (Result_WB !== 32'h55 || sc !== 0) begin errors++;
      $display("FAIL stray_after: res=%h stall=%0d expected 55 0", Result_WB, sc); end
  endtask

  task automatic test_reset_mid_access();
    RegWrite_MEM = 1; MemToReg_MEM = 1; AluOut_MEM = 32'h300; WriteReg_MEM = 5'd12;
    dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (dmem_req !== 1) begin errors++;
      $display("FAIL rst_mid_setup: req=%b expected 1", dmem_req); end
    #2;
    reset = 1; clearIn(); dmem_rdata = 32'hCAFEF00D;
    #1;
    checks++; if (dmem_req !== 0 || dmem_addr !== 0 || Stall_MEM !== 0 || RegWrite_WB !== 0 || Result_WB !== 0) begin errors++;
      $display("FAIL rst_mid_abort: req=%b addr=%h stall=%b rw=%b res=%h expected all 0",
               dmem_req, dmem_addr, Stall_MEM, RegWrite_WB, Result_WB); end
    @(negedge clk);
    reset = 0;
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (dmem_req !== 0 || RegWrite_WB !== 0 || Result_WB !== 0) begin errors++;
        $display("FAIL rst_late_ack: cycle=%0d req=%b rw=%b res=%h expected 0 0 0", i, dmem_req, RegWrite_WB, Result_WB); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jal();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
